// File: rtl/store_aligner_pkg.sv
// Shared types for the store aligner.
//   size_e  : request size encoding (byte, half, word; code 3 behaves as word)
//   state_e : beat sequencer states
//   size_bytes() : number of byte lanes a request of a given size touches
package store_aligner_pkg;

  typedef enum logic [1:0] {
    SizeByte    = 2'd0,
    SizeHalf    = 2'd1,
    SizeWord    = 2'd2,
    SizeWordAlt = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2
  } state_e;

  // Lanes covered by a store of the given size on a bus with 'lanes' byte lanes.
  function automatic int unsigned size_bytes(size_e size, int unsigned lanes);
    int unsigned n;
    unique case (size)
      SizeByte: n = 1;
      SizeHalf: n = 2;
      default:  n = lanes;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane shifter for the store aligner.
// Masks right-justified store data to its size, then places it (and its byte
// strobe) into a double-width window starting at the byte offset within a word.
//   i_data   : right-justified store data (W bits)
//   i_size   : size code
//   i_offset : byte offset within the word
//   o_image  : 2W-bit data window; low half is the first beat, high half the second
//   o_strobe : 2B-bit byte enables matching o_image
module store_lane_shifter
  import store_aligner_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [2**N-1:0]     i_data,
  input  size_e               i_size,
  input  logic [N-4:0]        i_offset,
  output logic [2**(N+1)-1:0] o_image,
  output logic [2**(N-2)-1:0] o_strobe
);

  localparam int unsigned W = 2**N;
  localparam int unsigned B = 2**(N-3);

  logic [B-1:0] w_lane_en;
  logic [W-1:0] w_data_masked;
  int unsigned  w_nbytes;

  always_comb begin
    w_nbytes      = size_bytes(i_size, B);
    w_lane_en     = '0;
    w_data_masked = '0;
    for (int i = 0; i < B; i++) begin
      w_lane_en[i] = (32'(i) < w_nbytes);
      if (w_lane_en[i]) begin
        w_data_masked[8*i +: 8] = i_data[8*i +: 8];
      end
    end
  end

  // Shift by whole bytes; the offset concatenated with three zeros is 8*offset.
  assign o_image  = {{W{1'b0}}, w_data_masked} << {i_offset, 3'b000};
  assign o_strobe = {{B{1'b0}}, w_lane_en} << i_offset;

endmodule

// File: rtl/store_aligner.sv
// Store aligner: turns a possibly misaligned byte/half/word store into one or
// two word-aligned write beats with byte strobes.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_addr/data/size     : byte address, right-justified data, size code
//   mem_valid/mem_ready    : beat handshake
//   mem_addr/wdata/wstrb   : aligned beat address, lane-positioned data, strobes
//   done                   : one-cycle pulse after the final beat is accepted
module store_aligner
  import store_aligner_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         req_addr,
  input  logic [2**N-1:0]     req_data,
  input  logic [1:0]          req_size,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [31:0]         mem_addr,
  output logic [2**N-1:0]     mem_wdata,
  output logic [2**(N-3)-1:0] mem_wstrb,
  output logic                done
);

  localparam int unsigned W = 2**N;
  localparam int unsigned B = 2**(N-3);
  localparam logic [31:0] BeatBytes = 32'(B);

  state_e         r_state, w_state_next;
  logic           r_mem_valid, w_mem_valid_next;
  logic [31:0]    r_mem_addr, w_mem_addr_next;
  logic [W-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic [B-1:0]   r_mem_wstrb, w_mem_wstrb_next;
  logic           r_done, w_done_next;
  // Second beat is computed at accept time and parked here until the first
  // beat is taken, so the outputs can be reloaded straight from flops.
  logic [31:0]    r_hi_addr, w_hi_addr_next;
  logic [W-1:0]   r_hi_wdata, w_hi_wdata_next;
  logic [B-1:0]   r_hi_wstrb, w_hi_wstrb_next;

  logic [2*W-1:0] w_image;
  logic [2*B-1:0] w_strobe;
  logic [31:0]    w_aligned;

  store_lane_shifter #(
    .N(N)
  ) u_shifter (
    .i_data  (req_data),
    .i_size  (size_e'(req_size)),
    .i_offset(req_addr[N-4:0]),
    .o_image (w_image),
    .o_strobe(w_strobe)
  );

  assign w_aligned = {req_addr[31:N-3], {(N-3){1'b0}}};

  always_comb begin
    w_state_next     = r_state;
    w_mem_valid_next = r_mem_valid;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_wstrb_next = r_mem_wstrb;
    w_done_next      = 1'b0;
    w_hi_addr_next   = r_hi_addr;
    w_hi_wdata_next  = r_hi_wdata;
    w_hi_wstrb_next  = r_hi_wstrb;

    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_state_next     = StLow;
          w_mem_valid_next = 1'b1;
          w_mem_addr_next  = w_aligned;
          w_mem_wdata_next = w_image[W-1:0];
          w_mem_wstrb_next = w_strobe[B-1:0];
          w_hi_addr_next   = w_aligned + BeatBytes;  // wraps mod 2**32
          w_hi_wdata_next  = w_image[2*W-1:W];
          w_hi_wstrb_next  = w_strobe[2*B-1:B];
        end
      end
      StLow: begin
        if (mem_ready) begin
          if (|r_hi_wstrb) begin
            w_state_next     = StHigh;
            w_mem_addr_next  = r_hi_addr;
            w_mem_wdata_next = r_hi_wdata;
            w_mem_wstrb_next = r_hi_wstrb;
          end else begin
            w_state_next     = StIdle;
            w_mem_valid_next = 1'b0;
            w_done_next      = 1'b1;
          end
        end
      end
      StHigh: begin
        if (mem_ready) begin
          w_state_next     = StIdle;
          w_mem_valid_next = 1'b0;
          w_done_next      = 1'b1;
        end
      end
      default: begin
        w_state_next     = StIdle;
        w_mem_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
      r_done      <= 1'b0;
      r_hi_addr   <= '0;
      r_hi_wdata  <= '0;
      r_hi_wstrb  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_valid <= w_mem_valid_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_wstrb <= w_mem_wstrb_next;
      r_done      <= w_done_next;
      r_hi_addr   <= w_hi_addr_next;
      r_hi_wdata  <= w_hi_wdata_next;
      r_hi_wstrb  <= w_hi_wstrb_next;
    end
  end

  assign req_ready = (r_state == StIdle);
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign done      = r_done;

endmodule
